// File: rtl/primegen_tbl_if.sv
// Handshake/result bundle for primegen_tbl: go request in, ready/error/res/idx out.
// The generator drives the slave side; the requester drives the master side.
interface primegen_tbl_if #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 16
);
  logic             go;
  logic             ready;
  logic             error;
  logic [WIDTH-1:0] res;
  logic [IDXW-1:0]  idx;

  modport master (output go, input ready, error, res, idx);
  modport slave  (input go, output ready, error, res, idx);
endinterface

// File: rtl/primegen_tbl.sv
// Next-prime generator: trial division by a table of odd primes via a bit-serial divider.
// 1->2->3 update in place; other steps take 1 cycle per CHECK + WIDTH per DIV; go ignored while busy.
module primegen_tbl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int IDXW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  primegen_tbl_if.slave   bus
);

  localparam int KW = $clog2(DEPTH + 1);
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_ERR} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_res, w_res_nxt;
  logic [IDXW-1:0]  r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_cand, w_cand_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [KW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_error, w_error_nxt;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [SW-1:0]    r_step;

  logic [WIDTH-1:0] r_tbl [DEPTH];

  logic             w_div_ld;
  logic             w_tbl_we;
  logic [TW-1:0]    w_tbl_wa;
  logic [WIDTH-1:0] w_tbl_wd;

  logic [WIDTH-1:0]   w_p;
  logic [2*WIDTH-1:0] w_psq;
  logic               w_prime;
  logic [WIDTH:0]     w_res_p2;
  logic [WIDTH:0]     w_cand_p2;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_df;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic               w_last;

  // k can reach DEPTH once the table is full; never index past the array.
  always_comb begin
    w_p = '0;
    if (r_k < KW'(DEPTH)) w_p = r_tbl[r_k[TW-1:0]];
  end

  assign w_psq     = {{WIDTH{1'b0}}, w_p} * {{WIDTH{1'b0}}, w_p};
  assign w_prime   = w_psq > {{WIDTH{1'b0}}, r_cand};
  assign w_res_p2  = {1'b0, r_res} + (WIDTH+1)'(2);
  assign w_cand_p2 = {1'b0, r_cand} + (WIDTH+1)'(2);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_rem_df  = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? w_rem_df[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_last    = (r_step == SW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_res_nxt   = r_res;
    w_idx_nxt   = r_idx;
    w_cand_nxt  = r_cand;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_error_nxt = r_error;
    w_div_ld    = 1'b0;
    w_tbl_we    = 1'b0;
    w_tbl_wa    = '0;
    w_tbl_wd    = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.go && !r_error) begin
          if (r_res == WIDTH'(1)) begin
            w_res_nxt = WIDTH'(2);
            w_idx_nxt = r_idx + IDXW'(1);
          end else if (r_res == WIDTH'(2)) begin
            w_res_nxt = WIDTH'(3);
            w_idx_nxt = r_idx + IDXW'(1);
            w_tbl_we  = 1'b1;
            w_tbl_wd  = WIDTH'(3);
            w_cnt_nxt = KW'(1);
          end else if (w_res_p2[WIDTH]) begin
            w_state_nxt = S_ERR;
            w_error_nxt = 1'b1;
          end else begin
            w_cand_nxt  = w_res_p2[WIDTH-1:0];
            w_k_nxt     = '0;
            w_ready_nxt = 1'b0;
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (r_k == r_cnt) begin
          w_state_nxt = S_ERR;
          w_error_nxt = 1'b1;
          w_ready_nxt = 1'b1;
        end else if (w_prime) begin
          w_res_nxt   = r_cand;
          w_idx_nxt   = r_idx + IDXW'(1);
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
          if (r_cnt < KW'(DEPTH)) begin
            w_tbl_we  = 1'b1;
            w_tbl_wa  = r_cnt[TW-1:0];
            w_tbl_wd  = r_cand;
            w_cnt_nxt = r_cnt + KW'(1);
          end
        end else begin
          w_div_ld    = 1'b1;
          w_state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        if (w_last) begin
          if (w_rem_nxt != '0) begin
            w_k_nxt     = r_k + KW'(1);
            w_state_nxt = S_CHECK;
          end else if (w_cand_p2[WIDTH]) begin
            w_state_nxt = S_ERR;
            w_error_nxt = 1'b1;
            w_ready_nxt = 1'b1;
          end else begin
            w_cand_nxt  = w_cand_p2[WIDTH-1:0];
            w_k_nxt     = '0;
            w_state_nxt = S_CHECK;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= WIDTH'(1);
      r_idx   <= '0;
      r_cand  <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_error <= 1'b0;
    end else begin
      r_res   <= w_res_nxt;
      r_idx   <= w_idx_nxt;
      r_cand  <= w_cand_nxt;
      r_k     <= w_k_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_step <= '0;
    end else if (w_div_ld) begin
      r_dvd  <= r_cand;
      r_rem  <= '0;
      r_dvs  <= w_p;
      r_step <= '0;
    end else if (r_state == S_DIV) begin
      r_dvd  <= {r_dvd[WIDTH-2:0], w_ge};
      r_rem  <= w_rem_nxt;
      r_step <= r_step + SW'(1);
    end
  end

  // Entries are only ever appended, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (w_tbl_we) r_tbl[w_tbl_wa] <= w_tbl_wd;
  end

  assign bus.ready = r_ready;
  assign bus.error = r_error;
  assign bus.res   = r_res;
  assign bus.idx   = r_idx;

endmodule

// File: tb/tb_primegen_tbl.sv
// Bench for primegen_tbl: three configurations (default, WIDTH=4, DEPTH=2/WIDTH=8)
// checked every cycle against an arithmetic next-prime model plus literal expectations.
module tb_primegen_tbl;

  logic clk = 1'b0;
  logic rst0_n, rst1_n, rst2_n;
  always #5 clk = ~clk;

  primegen_tbl_if #(.WIDTH(16), .IDXW(16)) if0 ();
  primegen_tbl_if #(.WIDTH(4),  .IDXW(16)) if1 ();
  primegen_tbl_if #(.WIDTH(8),  .IDXW(16)) if2 ();

  primegen_tbl #(.WIDTH(16), .DEPTH(32), .IDXW(16)) u0 (.clk(clk), .rst_n(rst0_n), .bus(if0));
  primegen_tbl #(.WIDTH(4),  .DEPTH(32), .IDXW(16)) u1 (.clk(clk), .rst_n(rst1_n), .bus(if1));
  primegen_tbl #(.WIDTH(8),  .DEPTH(2),  .IDXW(16)) u2 (.clk(clk), .rst_n(rst2_n), .bus(if2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     dw [3] = '{16, 4, 8};
  int     dd [3] = '{32, 32, 2};
  longint m_res_old [3], m_res_new [3], m_idx_old [3], m_idx_new [3];
  bit     m_err [3];
  int     m_done [3];
  bit     m_chk [3] = '{1'b1, 1'b1, 1'b1};
  longint m_tbl [3][64];
  int     m_cnt [3];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint g_res(input int d);
    case (d)
      0:       return longint'(if0.res);
      1:       return longint'(if1.res);
      default: return longint'(if2.res);
    endcase
  endfunction

  function automatic longint g_idx(input int d);
    case (d)
      0:       return longint'(if0.idx);
      1:       return longint'(if1.idx);
      default: return longint'(if2.idx);
    endcase
  endfunction

  function automatic bit g_ready(input int d);
    case (d)
      0:       return if0.ready;
      1:       return if1.ready;
      default: return if2.ready;
    endcase
  endfunction

  function automatic bit g_err(input int d);
    case (d)
      0:       return if0.error;
      1:       return if1.error;
      default: return if2.error;
    endcase
  endfunction

  function automatic bit g_x(input int d);
    case (d)
      0:       return $isunknown({if0.ready, if0.error, if0.res, if0.idx});
      1:       return $isunknown({if1.ready, if1.error, if1.res, if1.idx});
      default: return $isunknown({if2.ready, if2.error, if2.res, if2.idx});
    endcase
  endfunction

  task automatic set_go(input int d, input logic v);
    case (d)
      0:       if0.go = v;
      1:       if1.go = v;
      default: if2.go = v;
    endcase
  endtask

  task automatic set_rst(input int d, input logic v);
    case (d)
      0:       rst0_n = v;
      1:       rst1_n = v;
      default: rst2_n = v;
    endcase
  endtask

  task automatic model_reset(input int d);
    m_res_old[d] = 1; m_res_new[d] = 1;
    m_idx_old[d] = 0; m_idx_new[d] = 0;
    m_err[d] = 1'b0; m_cnt[d] = 0; m_done[d] = 0;
  endtask

  // Next prime by trial division over known odd primes; latency is one cycle per
  // trial plus WIDTH per division actually performed.
  task automatic model_go(input int d, input int acc);
    longint c, p, maxv;
    int     k, lat;
    bit     err, found;
    maxv = (64'd1 << dw[d]) - 1;
    m_res_old[d] = m_res_new[d];
    m_idx_old[d] = m_idx_new[d];
    m_done[d]    = acc;
    if (m_err[d]) return;
    lat = 0;
    if (m_res_new[d] == 1) begin
      m_res_new[d] = 2;
      m_idx_new[d] = (m_idx_new[d] + 1) & 16'hFFFF;
    end else if (m_res_new[d] == 2) begin
      m_res_new[d] = 3;
      m_idx_new[d] = (m_idx_new[d] + 1) & 16'hFFFF;
      m_tbl[d][0] = 3;
      m_cnt[d] = 1;
    end else begin
      c = m_res_new[d] + 2;
      err = (c > maxv);
      found = 1'b0;
      k = 0;
      while (!err && !found) begin
        lat++;
        if (k == m_cnt[d]) err = 1'b1;
        else begin
          p = m_tbl[d][k];
          if (p * p > c) found = 1'b1;
          else begin
            lat += dw[d];
            if (c % p == 0) begin
              c += 2;
              k = 0;
              if (c > maxv) err = 1'b1;
            end else k++;
          end
        end
      end
      if (found) begin
        m_res_new[d] = c;
        m_idx_new[d] = (m_idx_new[d] + 1) & 16'hFFFF;
        if (m_cnt[d] < dd[d]) begin
          m_tbl[d][m_cnt[d]] = c;
          m_cnt[d]++;
        end
      end
      if (err) m_err[d] = 1'b1;
    end
    m_done[d] = acc + lat;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (m_chk[d]) begin
        chk($sformatf("d%0d_no_x", d), longint'(g_x(d)), 0);
        if (cyc < m_done[d]) begin
          chk($sformatf("d%0d_busy_ready", d), longint'(g_ready(d)), 0);
          chk($sformatf("d%0d_busy_res", d), g_res(d), m_res_old[d]);
          chk($sformatf("d%0d_busy_idx", d), g_idx(d), m_idx_old[d]);
          chk($sformatf("d%0d_busy_error", d), longint'(g_err(d)), 0);
        end else begin
          chk($sformatf("d%0d_ready", d), longint'(g_ready(d)), 1);
          chk($sformatf("d%0d_res", d), g_res(d), m_res_new[d]);
          chk($sformatf("d%0d_idx", d), g_idx(d), m_idx_new[d]);
          chk($sformatf("d%0d_error", d), longint'(g_err(d)), longint'(m_err[d]));
        end
      end
    end
  end

  // One go pulse; optionally a stray go during the busy window or a reset mid-step.
  task automatic run_step(input int d, input int pulse_at, input int rst_at, output int lat);
    int acc;
    lat = -1;
    @(negedge clk);
    set_go(d, 1'b1);
    @(posedge clk);
    #1;
    set_go(d, 1'b0);
    acc = cyc;
    model_go(d, acc);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == rst_at) begin
        #2;
        set_rst(d, 1'b0);
        model_reset(d);
        #1;
        chk("midreset_res", g_res(d), 1);
        chk("midreset_idx", g_idx(d), 0);
        chk("midreset_ready", longint'(g_ready(d)), 1);
        chk("midreset_error", longint'(g_err(d)), 0);
        return;
      end
      if (g_ready(d)) begin
        lat = cyc - acc;
        break;
      end
      if (i == pulse_at) set_go(d, 1'b1);
      else if (i == pulse_at + 1) set_go(d, 1'b0);
    end
    set_go(d, 1'b0);
    if (lat < 0) chk("ready_timeout", 0, 1);
  endtask

  longint seq0 [12] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};
  longint seq2 [9]  = '{2, 3, 5, 7, 11, 13, 17, 19, 23};
  longint stuck [4] = '{2, 3, 5, 7};

  initial begin
    int     lat;
    int     n;
    longint last;
    longint got [4];
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_go(d, 1'b0);
      model_reset(d);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("reset_res", g_res(0), 1);
    chk("reset_idx", g_idx(0), 0);
    chk("reset_ready", longint'(g_ready(0)), 1);
    chk("reset_error", longint'(g_err(0)), 0);
    @(negedge clk);
    #2;
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_step(0, (i == 4) ? 5 : -1, -1, lat);
      chk($sformatf("seq_res_%0d", i + 1), g_res(0), seq0[i]);
      chk($sformatf("seq_idx_%0d", i + 1), g_idx(0), i + 1);
      if (i == 2) chk("lat_3_to_5", lat, 1);
      if (i == 3) chk("lat_5_to_7", lat, 1);
      if (i == 4) chk("lat_7_to_11", lat, 35);
    end
    chk("seq_error", longint'(g_err(0)), 0);

    run_step(0, -1, 8, lat);
    @(negedge clk);
    #2;
    rst0_n = 1'b1;
    run_step(0, -1, -1, lat);
    chk("restart_res", g_res(0), 2);
    chk("restart_idx", g_idx(0), 1);

    for (int i = 0; i < 6; i++) run_step(1, -1, -1, lat);
    chk("w4_pre_res", g_res(1), 13);
    run_step(1, -1, -1, lat);
    chk("ovf_error", longint'(g_err(1)), 1);
    chk("ovf_ready", longint'(g_ready(1)), 1);
    chk("ovf_res", g_res(1), 13);
    chk("ovf_idx", g_idx(1), 6);
    chk("ovf_lat", lat, 5);
    run_step(1, -1, -1, lat);
    chk("ovf_again_res", g_res(1), 13);
    chk("ovf_again_idx", g_idx(1), 6);
    chk("ovf_again_error", longint'(g_err(1)), 1);

    for (int i = 0; i < 9; i++) begin
      run_step(2, -1, -1, lat);
      chk($sformatf("d2_res_%0d", i + 1), g_res(2), seq2[i]);
    end
    run_step(2, -1, -1, lat);
    chk("exh_error", longint'(g_err(2)), 1);
    chk("exh_ready", longint'(g_ready(2)), 1);
    chk("exh_res", g_res(2), 23);
    chk("exh_idx", g_idx(2), 9);

    m_chk[0] = 1'b0;
    @(negedge clk);
    #2;
    rst0_n = 1'b0;
    model_reset(0);
    set_go(0, 1'b1);
    @(negedge clk);
    #2;
    rst0_n = 1'b1;
    n = 0;
    last = 1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (g_res(0) != last) begin
        last = g_res(0);
        got[n] = last;
        n++;
      end
    end
    chk("stuck_count", n, 4);
    for (int i = 0; i < n; i++) chk($sformatf("stuck_res_%0d", i), got[i], stuck[i]);
    set_go(0, 1'b0);
    #1;
    rst0_n = 1'b0;
    model_reset(0);
    m_chk[0] = 1'b1;
    @(negedge clk);
    #2;
    rst0_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
